// File: rtl/k_sram_buffer_if.sv
// k_sram_buffer_if: K-vector fill handshake, replay stream and pass status.
// Master side is upstream/datapath, slave side is the buffer.
`ifndef MAX_SEQ_LEN
`define MAX_SEQ_LEN 4
`endif

interface k_sram_buffer_if #(
    parameter int DEPTH      = `MAX_SEQ_LEN,
    parameter int NUM_PASSES = `MAX_SEQ_LEN,
    parameter int KW         = 64
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;

    logic          ctrl_K_vld;
    logic [KW-1:0] loaded_K_vector;
    logic          K_sram_rdy;
    logic          clear;
    logic          k_out_vld;
    logic          k_out_rdy;
    logic [KW-1:0] k_out_vector;
    logic [IW-1:0] k_out_idx;
    logic          k_out_last;
    logic [PW-1:0] pass_idx;
    logic          done;

    modport master (
        output ctrl_K_vld,
        output loaded_K_vector,
        output clear,
        output k_out_rdy,
        input  K_sram_rdy,
        input  k_out_vld,
        input  k_out_vector,
        input  k_out_idx,
        input  k_out_last,
        input  pass_idx,
        input  done
    );

    modport slave (
        input  ctrl_K_vld,
        input  loaded_K_vector,
        input  clear,
        input  k_out_rdy,
        output K_sram_rdy,
        output k_out_vld,
        output k_out_vector,
        output k_out_idx,
        output k_out_last,
        output pass_idx,
        output done
    );
endinterface

// File: rtl/k_sram_buffer.sv
// k_sram_buffer: fills DEPTH K vectors, then replays them NUM_PASSES times.
// Optional K_SRAM_STALL_CNT_EN adds a saturating stall_cycles counter port.
`ifndef MAX_SEQ_LEN
`define MAX_SEQ_LEN 4
`endif

module k_sram_buffer #(
    parameter int DEPTH      = `MAX_SEQ_LEN,
    parameter int NUM_PASSES = `MAX_SEQ_LEN,
    parameter int KW         = 64
) (
    input  logic              clk,
    input  logic              rst,
`ifdef K_SRAM_STALL_CNT_EN
    output logic [31:0]       stall_cycles,
`endif
    k_sram_buffer_if.slave    kbuf_io
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
    localparam logic [IW-1:0] LAST_IDX  = IW'(DEPTH - 1);
    localparam logic [PW-1:0] LAST_PASS = PW'(NUM_PASSES - 1);

    typedef enum logic [1:0] {
        S_FILL,
        S_LOAD,
        S_STREAM,
        S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic [KW-1:0] mem_q [DEPTH];
    logic [IW-1:0] wr_ptr_q, wr_ptr_d;
    logic [IW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] pass_q, pass_d;
    logic          rdy_q, rdy_d;
    logic          vld_q, vld_d;
    logic [KW-1:0] vec_q, vec_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          last_q, last_d;
    logic          done_q, done_d;
    logic          wr_en;
    logic          fill_hs;
    logic          out_hs;

    assign fill_hs = kbuf_io.ctrl_K_vld & rdy_q;
    assign out_hs  = vld_q & kbuf_io.k_out_rdy;

    // Explicit wrap so non-power-of-2 depths never index past DEPTH-1
    function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] p);
        return (p == LAST_IDX) ? '0 : p + IW'(1);
    endfunction

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        pass_d   = pass_q;
        vld_d    = vld_q;
        vec_d    = vec_q;
        idx_d    = idx_q;
        last_d   = last_q;
        done_d   = done_q;
        wr_en    = 1'b0;
        if (kbuf_io.clear) begin
            state_d  = S_FILL;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            pass_d   = '0;
            vld_d    = 1'b0;
            idx_d    = '0;
            last_d   = 1'b0;
            done_d   = 1'b0;
        end else begin
            unique case (state_q)
                S_FILL: begin
                    if (fill_hs) begin
                        wr_en    = 1'b1;
                        wr_ptr_d = next_ptr(wr_ptr_q);
                        if (wr_ptr_q == LAST_IDX) begin
                            state_d = S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    vec_d    = mem_q[0];
                    idx_d    = '0;
                    last_d   = (DEPTH == 1);
                    vld_d    = 1'b1;
                    rd_ptr_d = next_ptr('0);
                    state_d  = S_STREAM;
                end
                S_STREAM: begin
                    if (out_hs) begin
                        if (last_q && (pass_q == LAST_PASS)) begin
                            vld_d   = 1'b0;
                            done_d  = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            // Next pass starts on the same edge: no bubble
                            if (last_q) begin
                                pass_d = pass_q + PW'(1);
                            end
                            vec_d    = mem_q[rd_ptr_q];
                            idx_d    = rd_ptr_q;
                            last_d   = (rd_ptr_q == LAST_IDX);
                            rd_ptr_d = next_ptr(rd_ptr_q);
                        end
                    end
                end
                S_DONE: begin
                end
                default: begin
                    state_d = S_FILL;
                end
            endcase
        end
        rdy_d = (state_d == S_FILL);
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= kbuf_io.loaded_K_vector;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_FILL;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            pass_q   <= '0;
            rdy_q    <= 1'b0;
            vld_q    <= 1'b0;
            vec_q    <= '0;
            idx_q    <= '0;
            last_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            pass_q   <= pass_d;
            rdy_q    <= rdy_d;
            vld_q    <= vld_d;
            vec_q    <= vec_d;
            idx_q    <= idx_d;
            last_q   <= last_d;
            done_q   <= done_d;
        end
    end

`ifdef K_SRAM_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (kbuf_io.clear) begin
            stall_d = '0;
        end else if (vld_q && !kbuf_io.k_out_rdy && !(&stall_q)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`endif

    assign kbuf_io.K_sram_rdy   = rdy_q;
    assign kbuf_io.k_out_vld    = vld_q;
    assign kbuf_io.k_out_vector = vec_q;
    assign kbuf_io.k_out_idx    = idx_q;
    assign kbuf_io.k_out_last   = last_q;
    assign kbuf_io.pass_idx     = pass_q;
    assign kbuf_io.done         = done_q;

    a_hold_stable: assert property (
        @(posedge clk) disable iff (rst)
        (vld_q && !kbuf_io.k_out_rdy && !kbuf_io.clear)
        |=> (vld_q && $stable(vec_q) && $stable(idx_q) && $stable(last_q))
    );

    a_done_idle: assert property (
        @(posedge clk) disable iff (rst)
        done_q |-> (!vld_q && !rdy_q)
    );
endmodule

// File: doc/k_sram_buffer.md
Name: k_sram_buffer

Overview:
- On-chip K-vector store that sits directly downstream of memory_controller during PH_LOAD_K.
- Accepts MAX_SEQ_LEN K vectors over a valid/ready handshake (ctrl_K_vld / K_sram_rdy / loaded_K_vector).
- Once full, replays the whole K sequence once per Q row to the attention datapath (FlashAttention inner loop), NUM_PASSES times, then reports done.

Parameters:
- DEPTH, `MAX_SEQ_LEN, number of K vectors stored (≥1).
- NUM_PASSES, `MAX_SEQ_LEN, number of full replays (one per Q vector, ≥1).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- ctrl_K_vld  in  1  memory_controller has a K vector on loaded_K_vector
- loaded_K_vector  in  K_VECTOR_T  K vector from memory_controller
- K_sram_rdy  out  1  buffer accepts a K vector this cycle
- clear  in  1  synchronous restart to FILL, contents discarded
- k_out_vld  out  1  k_out_vector valid to datapath
- k_out_rdy  in  1  datapath consumes k_out_vector
- k_out_vector  out  K_VECTOR_T  registered K vector
- k_out_idx  out  $clog2(DEPTH) (min 1)  index of k_out_vector within sequence
- k_out_last  out  1  k_out_vector is entry DEPTH-1 of current pass
- pass_idx  out  $clog2(NUM_PASSES) (min 1)  current pass number
- done  out  1  all passes delivered

Behaviour:
- Reset (async): state=FILL, wr_ptr=0, rd_ptr=0, pass_idx=0; K_sram_rdy=0 during reset, 1 from first cycle after; k_out_vld=0, k_out_vector=0, k_out_idx=0, k_out_last=0, done=0. Array contents need not reset.
- Storage: DEPTH×K_VECTOR_T flop array, combinational read, registered output stage.
- FILL:
  - K_sram_rdy=1.
  - Handshake = ctrl_K_vld & K_sram_rdy; writes mem[wr_ptr], wr_ptr++.
  - On handshake with wr_ptr==DEPTH-1: wr_ptr→0, state→LOAD.
  - ctrl_K_vld without handshake is impossible in FILL. Vld/data are held by upstream.
- LOAD (one cycle, bubble):
  - K_sram_rdy=0.
  - Output reg ← mem[0], k_out_idx=0, k_out_last=(DEPTH==1), k_out_vld←1, rd_ptr←1 (wraps to 0 if DEPTH==1), state→STREAM.
  - First k_out_vld is therefore 2 edges after the final write edge.
- STREAM:
  - K_sram_rdy=0. Output held stable while k_out_vld & !k_out_rdy.
  - On k_out_vld & k_out_rdy (not last): output reg ← mem[rd_ptr], idx=rd_ptr, last=(rd_ptr==DEPTH-1), rd_ptr wraps DEPTH-1→0. Back-to-back transfers at 1/cycle, no bubbles within or between passes.
  - On handshake with k_out_last and pass_idx<NUM_PASSES-1: pass_idx++, next entry (idx 0) loaded same edge.
  - On handshake with k_out_last and pass_idx==NUM_PASSES-1: k_out_vld←0, done←1, state→DONE.
- DONE: done=1, k_out_vld=0, K_sram_rdy=0; stays until clear or rst.
- clear (any state, synchronous, highest priority after rst): next state FILL, pointers/pass_idx/done/k_out_vld←0. A handshake in the same cycle as clear is ignored (write dropped, output not advanced).
- rst mid-FILL or mid-STREAM: immediate return to reset values; partial data discarded.
- Counter widths: pointers compare against DEPTH-1 explicitly (non-power-of-2 DEPTH must wrap correctly).

Optional Feature:
- Macro K_SRAM_STALL_CNT_EN.
- Defined: adds output port stall_cycles (32 bits).
  - Increments each cycle k_out_vld & !k_out_rdy, saturating at all-ones.
  - Reset to 0 by rst or clear; holds in DONE.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- DEPTH=4, NUM_PASSES=2, upstream vld every cycle with vectors A,B,C,D; k_out_rdy=1 → rdy high 4 cycles, k_out_vld rises 2 edges after D accepted; outputs A,B,C,D,A,B,C,D on 8 consecutive cycles; last on D both passes; pass_idx 0→1; done=1 the cycle after the second D.
- Upstream vld toggling 1,0,1,0… during FILL → only valid-cycle vectors stored in order; wr_ptr advances only on handshake.
- Random k_out_rdy (~50%) during STREAM → k_out_vector/idx/last stable while stalled; sequence unchanged; with K_SRAM_STALL_CNT_EN, stall_cycles equals count of vld&!rdy cycles.
- DEPTH=3 (non power of 2), NUM_PASSES=3 → idx sequence 0,1,2,0,1,2,0,1,2; last on each idx 2; done after 9 transfers.
- Assert clear mid-STREAM (pass 1, idx 2) → next cycle k_out_vld=0, K_sram_rdy=1, pass_idx=0; refill with new vectors E..H streams E..H.
- Assert async rst mid-FILL after 2 writes, without a clock edge → outputs immediately at reset values; after release the full 4-vector fill is required before any k_out_vld.
